// File: rtl/timer_counter_if.sv
// Control/status bundle between the timer register block (master) and the
// counting stage (slave).
interface timer_counter_if #(
   parameter int CNT_W = 8
);
   logic             load;
   logic             updw;
   logic             en;
   logic [1:0]       cks;
   logic [CNT_W-1:0] tdr;
   logic [CNT_W-1:0] tcnt;
   logic             ovf_trig;
   logic             udf_trig;

   modport master (
      output load, updw, en, cks, tdr,
      input  tcnt, ovf_trig, udf_trig
   );

   modport slave (
      input  load, updw, en, cks, tdr,
      output tcnt, ovf_trig, udf_trig
   );
endinterface

// File: rtl/timer_counter.sv
// Counting stage of the 8-bit timer: prescaler, up/down counter, load-edge
// detection and single-cycle wrap triggers for the register block.
// DIV_W must be at least 4 so that every cks setting has a compare bit.
module timer_counter #(
   parameter int CNT_W = 8,
   parameter int DIV_W = 4
) (
   input  logic           pclk,
   input  logic           preset_n,
   timer_counter_if.slave tif
);

   logic             load_d;
   logic             ld_edge;
   logic [DIV_W-1:0] divider;
   logic [DIV_W-1:0] div_mask;
   logic             tick;
   logic             cnt_max;
   logic             cnt_min;
   logic [CNT_W-1:0] tcnt;
   logic             ovf_trig;
   logic             udf_trig;

   assign ld_edge  = tif.load & ~load_d;
   // mask selects divider bits [cks:0]; all selected bits set means tick
   assign div_mask = (DIV_W'(2) << tif.cks) - DIV_W'(1);
   assign tick     = tif.en & ((divider & div_mask) == div_mask);
   assign cnt_max  = (tcnt == {CNT_W{1'b1}});
   assign cnt_min  = (tcnt == {CNT_W{1'b0}});

   // registered copy of load for rising-edge detection
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) load_d <= 1'b0;
      else           load_d <= tif.load;
   end

   // free-running prescaler; held clear while disabled, restarted by a load
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n)                divider <= '0;
      else if (!tif.en || ld_edge)  divider <= '0;
      else                          divider <= divider + DIV_W'(1);
   end

   // counter: load edge wins over any tick in the same cycle
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n)      tcnt <= '0;
      else if (ld_edge)   tcnt <= tif.tdr;
      else if (tick) begin
         if (!tif.updw)   tcnt <= tcnt + CNT_W'(1);
         else             tcnt <= tcnt - CNT_W'(1);
      end
   end

   // wrap triggers land on the same edge as the wrapped count value
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         ovf_trig <= 1'b0;
         udf_trig <= 1'b0;
      end else begin
         ovf_trig <= tick & ~ld_edge & ~tif.updw & cnt_max;
         udf_trig <= tick & ~ld_edge &  tif.updw & cnt_min;
      end
   end

   assign tif.tcnt     = tcnt;
   assign tif.ovf_trig = ovf_trig;
   assign tif.udf_trig = udf_trig;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: the stimulus process predicts each
// cycle's outputs from a behavioural model and queues them; the monitor pops
// one entry after every clock edge and compares.
module tb_timer_counter;

   typedef struct {
      logic [7:0] cnt;
      logic       ovf;
      logic       udf;
   } exp_t;

   logic pclk;
   logic preset_n;

   timer_counter_if #(.CNT_W(8)) tif ();

   timer_counter #(.CNT_W(8), .DIV_W(4)) dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .tif      (tif)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   ovf_seen = 0;
   int   udf_seen = 0;
   int   nstep = 0;

   // behavioural model state: count value, enabled cycles since the
   // prescaler last restarted, previous load level
   int m_cnt = 0;
   int m_run = 0;
   bit m_ld_prev = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // drive one cycle of inputs and queue the outputs expected after the edge
   task automatic step(input bit ld, input bit ud, input bit e,
                       input int ck, input int d);
      int   per;
      bit   edge_s;
      bit   tick;
      exp_t x;
      @(negedge pclk);
      tif.load = ld;
      tif.updw = ud;
      tif.en   = e;
      tif.cks  = 2'(ck);
      tif.tdr  = 8'(d);
      per    = 2 << ck;
      edge_s = ld && !m_ld_prev;
      tick   = e && ((m_run % per) == per - 1);
      x.ovf  = 1'b0;
      x.udf  = 1'b0;
      if (edge_s) begin
         m_cnt = d & 255;
      end else if (tick) begin
         if (!ud) begin
            x.ovf = (m_cnt == 255);
            m_cnt = (m_cnt + 1) % 256;
         end else begin
            x.udf = (m_cnt == 0);
            m_cnt = (m_cnt + 255) % 256;
         end
      end
      m_run     = (!e || edge_s) ? 0 : m_run + 1;
      m_ld_prev = ld;
      x.cnt     = 8'(m_cnt);
      sb.push_back(x);
   endtask

   task automatic do_reset();
      @(posedge pclk);
      #3;
      tif.load = 0; tif.updw = 0; tif.en = 0; tif.cks = 0; tif.tdr = 0;
      preset_n = 1'b0;
      #1;
      chk("rst_tcnt", int'(tif.tcnt), 0);
      chk("rst_ovf", int'(tif.ovf_trig), 0);
      chk("rst_udf", int'(tif.udf_trig), 0);
      m_cnt = 0; m_run = 0; m_ld_prev = 0;
      @(negedge pclk);
      preset_n = 1'b1;
   endtask

   // monitor: one expected entry per clock edge while stimulus is active
   initial begin
      exp_t x;
      forever begin
         @(posedge pclk);
         #1;
         if (sb.size() > 0) begin
            x = sb.pop_front();
            nstep++;
            total++;
            if (tif.ovf_trig === 1'b1) ovf_seen++;
            if (tif.udf_trig === 1'b1) udf_seen++;
            if (tif.tcnt !== x.cnt || tif.ovf_trig !== x.ovf || tif.udf_trig !== x.udf) begin
               bad++;
               $display("FAIL cycle%0d: got tcnt=%h ovf=%b udf=%b expected tcnt=%h ovf=%b udf=%b",
                        nstep, tif.tcnt, tif.ovf_trig, tif.udf_trig, x.cnt, x.ovf, x.udf);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit ld, e, ud;
      int ck, d;
      preset_n = 1'b0;
      tif.load = 0; tif.updw = 0; tif.en = 0; tif.cks = 0; tif.tdr = 0;

      // reset state, then idle with en=0
      do_reset();
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 8'h00);

      // mid-count reset with tcnt=37
      step(1, 0, 0, 0, 8'h37);
      step(0, 0, 1, 0, 8'h37);
      do_reset();
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 8'h00);

      // overflow at /2: FE -> FF -> 00 with ovf
      ovf_seen = 0; udf_seen = 0;
      step(1, 0, 0, 0, 8'hFE);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 8'hFE);
      @(posedge pclk); #2;
      chk("ovf_div2_count", ovf_seen, 1);
      chk("ovf_div2_udf", udf_seen, 0);

      // underflow at /16: 01 -> 00 -> FF with udf
      ovf_seen = 0; udf_seen = 0;
      step(1, 1, 0, 3, 8'h01);
      for (int i = 0; i < 40; i++) step(0, 1, 1, 3, 8'h01);
      @(posedge pclk); #2;
      chk("udf_div16_count", udf_seen, 1);
      chk("udf_div16_ovf", ovf_seen, 0);

      // load held high while tdr changes: single reload
      step(0, 0, 1, 0, 8'h10);
      for (int i = 0; i < 10; i++) step(1, 0, 1, 0, (i < 5) ? 8'h10 : 8'h20);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 8'h20);

      // load edge coincident with tick at FF: load wins, no ovf
      ovf_seen = 0;
      step(1, 0, 0, 0, 8'hFF);
      step(0, 0, 1, 0, 8'hFF);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 8'h55);
      @(posedge pclk); #2;
      chk("load_on_tick_ovf", ovf_seen, 0);
      chk("load_on_tick_tcnt", int'(tif.tcnt), 8'h56);

      // enable gating at /4: freeze at 42, restart full period
      step(1, 0, 0, 1, 8'h40);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 8'h40);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 8'h40);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 8'h40);

      // direction switch at 00: next tick gives FF with udf
      ovf_seen = 0; udf_seen = 0;
      step(1, 0, 0, 0, 8'hFF);
      step(0, 0, 1, 0, 8'hFF);
      step(0, 0, 1, 0, 8'hFF);
      step(0, 1, 1, 0, 8'hFF);
      step(0, 1, 1, 0, 8'hFF);
      @(posedge pclk); #2;
      chk("dir_switch_tcnt", int'(tif.tcnt), 8'hFF);
      chk("dir_switch_udf", udf_seen, 1);
      chk("dir_switch_ovf", ovf_seen, 1);

      // randomized run with a reset in the middle
      ud = 0; ck = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         ld = ($urandom_range(0, 19) == 0);
         e  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 49) == 0) ud = ~ud;
         if ($urandom_range(0, 99) == 0) ck = $urandom_range(0, 3);
         case ($urandom_range(0, 5))
            0: d = 8'hFF;
            1: d = 8'hFE;
            2: d = 8'h00;
            3: d = 8'h01;
            default: d = $urandom_range(0, 255);
         endcase
         step(ld, ud, e, ck, d);
      end

      @(posedge pclk); #2;
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Counting stage of the 8-bit timer. Sits directly downstream of the APB timer register block.
- Consumes the control fields load, updw, en, cks and the tdr reload value.
- Produces single-cycle ovf_trig and udf_trig pulses, which the register block latches into TSR.
- Contains the clock prescaler, the 8-bit up/down counter, load-edge detection and wrap detection.

Parameters:
- CNT_W, 8, counter and tdr width.
- DIV_W, 4, prescaler divider width; must be at least 4 so all cks settings are valid.

Ports:
- pclk  input  1  system clock; all state updates on its rising edge.
- preset_n  input  1  asynchronous active-low reset.
- load  input  1  TCR load bit; a rising edge reloads the counter from tdr.
- updw  input  1  count direction: 0 = up, 1 = down.
- en  input  1  count enable.
- cks  input  2  prescaler select.
- tdr  input  CNT_W  reload value.
- tcnt  output  CNT_W  current counter value.
- ovf_trig  output  1  one-cycle pulse on up-count wrap from FF to 00.
- udf_trig  output  1  one-cycle pulse on down-count wrap from 00 to FF.

Behaviour:
- Reset: applies asynchronously on preset_n low.
  - tcnt = 8'h00, ovf_trig = 0, udf_trig = 0.
  - Divider = 0, load_d (registered copy of load) = 0.
  - Reset mid-count discards all state immediately.
  - After reset release, no tick or trigger occurs until en=1.
- Load edge detection:
  - load_d <= load every cycle.
  - ld_edge = load & ~load_d.
  - Holding load high reloads exactly once; a new 0->1 transition is required to reload again.
- Prescaler:
  - While en=1, the DIV_W-bit divider increments every cycle and wraps naturally.
  - While en=0, the divider is held at 0.
  - ld_edge clears the divider to 0.
  - tick = en & (divider[cks:0] == all ones), so the tick period is 2^(cks+1) pclk cycles.
  - cks 00 gives /2, 01 gives /4, 10 gives /8, 11 gives /16.
  - A cks change takes effect on the next compare; the divider is not reset by it.
- Counter update priority, highest first:
  1. ld_edge: tcnt <= tdr. Applies even when en=0. Any tick in that cycle is discarded, and no trigger is produced.
  2. tick and updw=0: tcnt <= tcnt+1, modulo 256.
  3. tick and updw=1: tcnt <= tcnt-1, modulo 256.
  4. Otherwise tcnt holds.
- Trigger generation (registered):
  - ovf_trig <= tick & ~ld_edge & ~updw & (tcnt == 8'hFF).
  - udf_trig <= tick & ~ld_edge & updw & (tcnt == 8'h00).
  - A trigger rises on the same edge at which tcnt takes its wrapped value, so ovf_trig=1 is visible together with tcnt=00.
  - Each trigger lasts exactly one pclk cycle; the outputs are never high simultaneously.
- en deasserted mid-count: tcnt freezes, no triggers are produced, and the divider clears. Re-enabling restarts a full prescale period.
- updw changed mid-count: the new direction applies from the next tick. A wrap in the new direction triggers per the new updw.
- Loading tdr=FF while counting up: produces no trigger on the load itself. The next tick wraps to 00 and pulses ovf_trig.
- Boundary: tcnt == tdr carries no special meaning; there is no auto-reload on wrap. The counter is free-running modulo 256.
- Implementation constraint: synthesizable only, with no delays in RTL.

Test Plan:
- Reset check: assert preset_n=0 mid-count with tcnt=8'h37 -> tcnt=00, ovf_trig=udf_trig=0 immediately. After release with en=0, tcnt stays 00 for 20 cycles.
- Overflow at /2: tdr=FE, pulse load, then en=1, updw=0, cks=00 -> tcnt FE->FF->00 with 2-cycle spacing. ovf_trig is high for exactly 1 cycle, coincident with tcnt=00; udf_trig stays 0.
- Underflow at /16: tdr=01, load, en=1, updw=1, cks=11 -> tcnt 01->00->FF with 16-cycle spacing. A single udf_trig pulse occurs at tcnt=FF.
- Load behaviour: hold load high for 10 cycles while en=1 and tdr changes from 10 to 20 -> tcnt=10 once, then counts from 10; no second reload. Load edge coincident with a tick on tcnt=FF up-counting -> tcnt=tdr and no ovf_trig.
- Enable gating: count up at cks=01, drop en for 7 cycles at tcnt=42 -> tcnt holds 42. Re-enable -> next increment exactly 4 cycles later.
- Direction switch: counting up at tcnt=00, switch updw to 1 -> next tick gives tcnt=FF with udf_trig=1 and ovf_trig=0.
